// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback path has priority, and
// auxiliary completions queue in a small FIFO that drains into idle or forced slots.
module rf_write_arbiter #(
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid_in,
  input  logic [4:0]  wb_rd_addr_in,
  input  logic [31:0] wb_rd_value_in,
  output logic        wb_stall_out,
  input  logic        aux_valid_in,
  input  logic [4:0]  aux_rd_addr_in,
  input  logic [31:0] aux_rd_value_in,
  output logic        aux_ready_out,
  output logic        aux_pend_out,
  output logic [4:0]  aux_pend_addr_out,
  output logic        rf_wr_en_out,
  output logic [4:0]  rf_rd_addr_out,
  output logic [31:0] rf_rd_value_out
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(BUF_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [4:0]    buf_addr  [BUF_DEPTH];
  logic [31:0]   buf_value [BUF_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic          wb_req;
  logic          force_drain;
  logic          push;
  logic          pop;
  logic [31:0]   head_value;
  logic          grant_en;
  logic [4:0]    grant_addr;
  logic [31:0]   grant_value;
  logic [CW-1:0] count_next;
  logic [SW-1:0] starve_next;

  assign aux_pend_out      = (count != '0);
  assign aux_pend_addr_out = buf_addr[rd_ptr];
  assign head_value        = buf_value[rd_ptr];
  assign aux_ready_out     = rst_n && (count != FULL_CNT);

  // The stall tracks the forced drain only, never the wb request, so it lasts one cycle.
  assign force_drain  = rst_n && aux_pend_out && (starve_cnt == STARVE_MAX);
  assign wb_stall_out = force_drain;

  assign wb_req = wb_valid_in && (wb_rd_addr_in != 5'd0);
  assign push   = aux_valid_in && aux_ready_out;

  always_comb begin
    pop         = 1'b0;
    grant_en    = 1'b0;
    grant_addr  = wb_rd_addr_in;
    grant_value = wb_rd_value_in;
    if (force_drain) begin
      pop         = 1'b1;
      grant_en    = (aux_pend_addr_out != 5'd0);
      grant_addr  = aux_pend_addr_out;
      grant_value = head_value;
    end else if (wb_req) begin
      grant_en = 1'b1;
    end else if (aux_pend_out) begin
      // A head aimed at x0 is still popped; it just never reaches the port.
      pop         = 1'b1;
      grant_en    = (aux_pend_addr_out != 5'd0);
      grant_addr  = aux_pend_addr_out;
      grant_value = head_value;
    end
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    starve_next = starve_cnt;
    if (pop || !aux_pend_out) begin
      starve_next = '0;
    end else if (wb_req && (starve_cnt != STARVE_MAX)) begin
      starve_next = starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count      <= count_next;
      starve_cnt <= starve_next;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[wr_ptr]  <= aux_rd_addr_in;
      buf_value[wr_ptr] <= aux_rd_value_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wr_en_out    <= 1'b0;
      rf_rd_addr_out  <= 5'd0;
      rf_rd_value_out <= 32'd0;
    end else begin
      rf_wr_en_out <= grant_en;
      if (grant_en) begin
        rf_rd_addr_out  <= grant_addr;
        rf_rd_value_out <= grant_value;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: expected register-file writes are queued
// as stimulus is driven and checked in order as rf_wr_en_out pulses.
module tb_rf_write_arbiter;

  localparam int BUF_DEPTH    = 2;
  localparam int STARVE_LIMIT = 4;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] value;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid_in;
  logic [4:0]  wb_rd_addr_in;
  logic [31:0] wb_rd_value_in;
  logic        wb_stall_out;
  logic        aux_valid_in;
  logic [4:0]  aux_rd_addr_in;
  logic [31:0] aux_rd_value_in;
  logic        aux_ready_out;
  logic        aux_pend_out;
  logic [4:0]  aux_pend_addr_out;
  logic        rf_wr_en_out;
  logic [4:0]  rf_rd_addr_out;
  logic [31:0] rf_rd_value_out;

  wr_t exp_q[$];
  wr_t aux_model[$];
  int  vectors     = 0;
  int  miscompares = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.BUF_DEPTH(BUF_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wb_valid_in       (wb_valid_in),
    .wb_rd_addr_in     (wb_rd_addr_in),
    .wb_rd_value_in    (wb_rd_value_in),
    .wb_stall_out      (wb_stall_out),
    .aux_valid_in      (aux_valid_in),
    .aux_rd_addr_in    (aux_rd_addr_in),
    .aux_rd_value_in   (aux_rd_value_in),
    .aux_ready_out     (aux_ready_out),
    .aux_pend_out      (aux_pend_out),
    .aux_pend_addr_out (aux_pend_addr_out),
    .rf_wr_en_out      (rf_wr_en_out),
    .rf_rd_addr_out    (rf_rd_addr_out),
    .rf_rd_value_out   (rf_rd_value_out)
  );

  // Every write pulse is matched against the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (rf_wr_en_out === 1'b1) begin
      vectors++;
      if (rf_rd_addr_out == 5'd0) begin
        miscompares++;
        $display("FAIL x0_write: got write to x0 value %h, required no x0 write", rf_rd_value_out);
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got x%0d=%h, required no write", rf_rd_addr_out, rf_rd_value_out);
      end else begin
        e = exp_q.pop_front();
        if (rf_rd_addr_out !== e.addr || rf_rd_value_out !== e.value) begin
          miscompares++;
          $display("FAIL write_order: got x%0d=%h, required x%0d=%h",
                   rf_rd_addr_out, rf_rd_value_out, e.addr, e.value);
        end
      end
    end
  end

  task automatic go_idle();
    wb_valid_in     = 1'b0;
    wb_rd_addr_in   = 5'd0;
    wb_rd_value_in  = 32'd0;
    aux_valid_in    = 1'b0;
    aux_rd_addr_in  = 5'd0;
    aux_rd_value_in = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    go_idle();
    aux_valid_in    = 1'b1;
    aux_rd_addr_in  = 5'd3;
    aux_rd_value_in = 32'h3333_3333;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (aux_ready_out !== 1'b0 || rf_wr_en_out !== 1'b0 || wb_stall_out !== 1'b0 || aux_pend_out !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: got ready=%b wr_en=%b stall=%b pend=%b, required 0 0 0 0",
                 i, aux_ready_out, rf_wr_en_out, wb_stall_out, aux_pend_out);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    go_idle();
    #1;
    vectors++;
    if (aux_ready_out !== 1'b1 || aux_pend_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got ready=%b pend=%b, required 1 0", aux_ready_out, aux_pend_out);
    end
  endtask

  task automatic test_idle_drain();
    // wb path: one-cycle latency
    @(negedge clk);
    wb_valid_in    = 1'b1;
    wb_rd_addr_in  = 5'd3;
    wb_rd_value_in = 32'h0000_0333;
    exp_q.push_back('{5'd3, 32'h0000_0333});
    @(negedge clk);
    go_idle();
    vectors++;
    if (rf_wr_en_out !== 1'b1 || rf_rd_addr_out !== 5'd3) begin
      miscompares++;
      $display("FAIL wb_latency: got wr_en=%b addr=%0d, required 1 3", rf_wr_en_out, rf_rd_addr_out);
    end
    // aux path: accepted, popped next cycle, written the cycle after
    @(negedge clk);
    aux_valid_in    = 1'b1;
    aux_rd_addr_in  = 5'd5;
    aux_rd_value_in = 32'hDEAD_BEEF;
    vectors++;
    if (aux_ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_ready: got %b, required 1", aux_ready_out);
    end
    exp_q.push_back('{5'd5, 32'hDEAD_BEEF});
    @(negedge clk);
    go_idle();
    vectors++;
    if (aux_pend_out !== 1'b1 || aux_pend_addr_out !== 5'd5 || rf_wr_en_out !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_pend: got pend=%b addr=%0d wr_en=%b, required 1 5 0",
               aux_pend_out, aux_pend_addr_out, rf_wr_en_out);
    end
    @(negedge clk);
    vectors++;
    if (rf_wr_en_out !== 1'b1 || rf_rd_addr_out !== 5'd5 || rf_rd_value_out !== 32'hDEAD_BEEF || aux_pend_out !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_write: got wr_en=%b x%0d=%h pend=%b, required 1 x5=deadbeef 0",
               rf_wr_en_out, rf_rd_addr_out, rf_rd_value_out, aux_pend_out);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_left: got %0d writes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_starvation();
    int k = 0;
    int c = 0;
    while (k < 9 && c < 20) begin
      @(negedge clk);
      wb_valid_in     = 1'b1;
      wb_rd_addr_in   = 5'(k + 1);
      wb_rd_value_in  = 32'hA000_0000 + 32'(k + 1);
      aux_valid_in    = (c == 0);
      aux_rd_addr_in  = 5'd7;
      aux_rd_value_in = 32'h0000_7777;
      vectors++;
      if (wb_stall_out !== 1'(c == STARVE_LIMIT + 1)) begin
        miscompares++;
        $display("FAIL starve_stall[c%0d]: got %b, required %b", c, wb_stall_out, (c == STARVE_LIMIT + 1));
      end
      if (aux_valid_in && aux_ready_out) aux_model.push_back('{aux_rd_addr_in, aux_rd_value_in});
      if (wb_stall_out) begin
        if (aux_model.size() != 0) exp_q.push_back(aux_model.pop_front());
      end else begin
        exp_q.push_back('{wb_rd_addr_in, wb_rd_value_in});
        k++;
      end
      c++;
    end
    vectors++;
    if (k != 9) begin
      miscompares++;
      $display("FAIL starve_bound: got %0d wb writes in %0d cycles, required 9", k, c);
    end
    @(negedge clk);
    go_idle();
    while (aux_model.size() != 0) exp_q.push_back(aux_model.pop_front());
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0 || aux_pend_out !== 1'b0) begin
      miscompares++;
      $display("FAIL starve_left: got %0d outstanding pend=%b, required 0 0", exp_q.size(), aux_pend_out);
    end
  endtask

  task automatic test_full_fifo();
    int k = 0;
    int a = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      wb_valid_in    = 1'b1;
      wb_rd_addr_in  = 5'(16 + k);
      wb_rd_value_in = 32'hB000_0000 + 32'(k);
      if (a < 3) begin
        aux_valid_in    = 1'b1;
        aux_rd_addr_in  = 5'(10 + a);
        aux_rd_value_in = 32'hC000_0000 + 32'(a);
        vectors++;
        if (aux_ready_out !== 1'(!(c >= 2 && c <= STARVE_LIMIT + 1))) begin
          miscompares++;
          $display("FAIL full_ready[c%0d]: got %b, required %b", c, aux_ready_out, !(c >= 2 && c <= STARVE_LIMIT + 1));
        end
      end else begin
        aux_valid_in = 1'b0;
      end
      if (aux_valid_in && aux_ready_out) begin
        aux_model.push_back('{aux_rd_addr_in, aux_rd_value_in});
        a++;
      end
      if (wb_stall_out) begin
        if (aux_model.size() != 0) exp_q.push_back(aux_model.pop_front());
      end else begin
        exp_q.push_back('{wb_rd_addr_in, wb_rd_value_in});
        k++;
      end
    end
    vectors++;
    if (a != 3) begin
      miscompares++;
      $display("FAIL full_accept: got %0d accepted, required 3", a);
    end
    @(negedge clk);
    go_idle();
    while (aux_model.size() != 0) exp_q.push_back(aux_model.pop_front());
    repeat (4) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0 || aux_pend_out !== 1'b0) begin
      miscompares++;
      $display("FAIL full_left: got %0d outstanding pend=%b, required 0 0", exp_q.size(), aux_pend_out);
    end
  endtask

  task automatic test_x0();
    // wb to x0 frees the slot for the pending aux entry
    @(negedge clk);
    wb_valid_in     = 1'b1;
    wb_rd_addr_in   = 5'd1;
    wb_rd_value_in  = 32'h0000_0101;
    aux_valid_in    = 1'b1;
    aux_rd_addr_in  = 5'd9;
    aux_rd_value_in = 32'h0000_0909;
    exp_q.push_back('{5'd1, 32'h0000_0101});
    @(negedge clk);
    aux_valid_in   = 1'b0;
    wb_rd_addr_in  = 5'd2;
    wb_rd_value_in = 32'h0000_0202;
    exp_q.push_back('{5'd2, 32'h0000_0202});
    @(negedge clk);
    wb_rd_addr_in  = 5'd0;
    wb_rd_value_in = 32'h0BAD_0BAD;
    exp_q.push_back('{5'd9, 32'h0000_0909});
    vectors++;
    if (wb_stall_out !== 1'b0 || aux_pend_out !== 1'b1) begin
      miscompares++;
      $display("FAIL x0_wb_slot: got stall=%b pend=%b, required 0 1", wb_stall_out, aux_pend_out);
    end
    @(negedge clk);
    go_idle();
    vectors++;
    if (rf_wr_en_out !== 1'b1 || rf_rd_addr_out !== 5'd9) begin
      miscompares++;
      $display("FAIL x0_wb_fill: got wr_en=%b addr=%0d, required 1 9", rf_wr_en_out, rf_rd_addr_out);
    end
    // aux entry aimed at x0 is dropped silently
    @(negedge clk);
    aux_valid_in    = 1'b1;
    aux_rd_addr_in  = 5'd0;
    aux_rd_value_in = 32'h0000_1234;
    @(negedge clk);
    aux_rd_addr_in  = 5'd13;
    aux_rd_value_in = 32'h0000_1313;
    exp_q.push_back('{5'd13, 32'h0000_1313});
    vectors++;
    if (aux_pend_out !== 1'b1 || aux_pend_addr_out !== 5'd0) begin
      miscompares++;
      $display("FAIL x0_aux_head: got pend=%b addr=%0d, required 1 0", aux_pend_out, aux_pend_addr_out);
    end
    @(negedge clk);
    go_idle();
    vectors++;
    if (rf_wr_en_out !== 1'b0 || rf_rd_addr_out !== 5'd9 || aux_pend_addr_out !== 5'd13) begin
      miscompares++;
      $display("FAIL x0_aux_pop: got wr_en=%b addr=%0d head=%0d, required 0 9 13",
               rf_wr_en_out, rf_rd_addr_out, aux_pend_addr_out);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0 || aux_pend_out !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_left: got %0d outstanding pend=%b, required 0 0", exp_q.size(), aux_pend_out);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    wb_valid_in     = 1'b1;
    wb_rd_addr_in   = 5'd1;
    wb_rd_value_in  = 32'hD000_0001;
    aux_valid_in    = 1'b1;
    aux_rd_addr_in  = 5'd20;
    aux_rd_value_in = 32'hE000_0020;
    exp_q.push_back('{5'd1, 32'hD000_0001});
    @(negedge clk);
    wb_rd_addr_in   = 5'd2;
    wb_rd_value_in  = 32'hD000_0002;
    aux_rd_addr_in  = 5'd21;
    aux_rd_value_in = 32'hE000_0021;
    exp_q.push_back('{5'd2, 32'hD000_0002});
    @(negedge clk);
    go_idle();
    vectors++;
    if (aux_ready_out !== 1'b0 || aux_pend_out !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_full: got ready=%b pend=%b, required 0 1", aux_ready_out, aux_pend_out);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (wb_stall_out !== 1'b0 || aux_ready_out !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_rst_comb: got stall=%b ready=%b, required 0 0", wb_stall_out, aux_ready_out);
    end
    @(negedge clk);
    vectors++;
    if (aux_pend_out !== 1'b0 || rf_wr_en_out !== 1'b0 || rf_rd_addr_out !== 5'd0 || rf_rd_value_out !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_rst_state: got pend=%b wr_en=%b x%0d=%h, required 0 0 x0=0",
               aux_pend_out, rf_wr_en_out, rf_rd_addr_out, rf_rd_value_out);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0 || aux_pend_out !== 1'b0 || aux_ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_after: got %0d outstanding pend=%b ready=%b, required 0 0 1",
               exp_q.size(), aux_pend_out, aux_ready_out);
    end
  endtask

  initial begin
    test_reset();
    test_idle_drain();
    test_starvation();
    test_full_fifo();
    test_x0();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
